// File: rtl/lab2_pkg.sv
// Shared types and helpers for the lab2 stages: default record layout,
// control-state encoding and a saturating increment.
package lab2_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int REC_W     = 8 + CNT_W_DEF;

  typedef struct packed {
    logic [7:0]           val;
    logic [CNT_W_DEF-1:0] cycles;
  } hold_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ctl_state_t;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    if (v >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/lab2_hold_meter_if.sv
// Valid/ready record stream leaving the hold meter: {held_value, hold_cycles}.
interface lab2_hold_meter_if #(
  parameter int CNT_W = 16
);
  logic               m_valid;
  logic               m_ready;
  logic [8+CNT_W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/lab2_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word,
// registered valid/level, and (AW+1)-bit wrapping pointers.
module lab2_sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW:0]   wr_r;
  logic [AW:0]   rd_r;
  logic [AW:0]   wr_nxt_s;
  logic [AW:0]   rd_nxt_s;
  logic [W-1:0]  dout_r;
  logic          valid_r;
  logic [AW:0]   level_r;
  logic [W-1:0]  head_nxt_s;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign empty = (wr_r == rd_r);
  assign full  = (wr_r[AW] != rd_r[AW]) && (wr_r[AW-1:0] == rd_r[AW-1:0]);
  assign dout  = dout_r;
  assign valid = valid_r;
  assign level = level_r;

  // Next pointers and the word that will sit at the head after this edge.
  always_comb begin
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
    rd_nxt_s  = rd_r + {{AW{1'b0}}, pop_ok_s};
    wr_nxt_s  = wr_r + {{AW{1'b0}}, push_ok_s};
    // A slot that is not yet written can only become the head via bypass.
    if (rd_nxt_s != wr_r) begin
      head_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
    end else if (push_ok_s) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = dout_r;
    end
  end

  // Storage array: written only on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_r[AW-1:0]] <= din;
    end
  end

  // Pointers and registered head/valid/level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_r    <= '0;
      rd_r    <= '0;
      dout_r  <= '0;
      valid_r <= 1'b0;
      level_r <= '0;
    end else begin
      wr_r    <= wr_nxt_s;
      rd_r    <= rd_nxt_s;
      dout_r  <= head_nxt_s;
      valid_r <= (wr_nxt_s != rd_nxt_s);
      level_r <= wr_nxt_s - rd_nxt_s;
    end
  end

endmodule

// File: rtl/lab2_hold_meter.sv
// Watches the lab2 output bus, and for every value change queues a record of
// the replaced value and how many edges it was held.
module lab2_hold_meter
  import lab2_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              din,
  lab2_hold_meter_if.master       m,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf
);

  localparam logic [31:0]      CNT_MAX32 = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  ctl_state_t          state_r;
  logic [7:0]          din_q_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ovf_r;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [31:0]         inc32_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;

  assign push_s = (state_r == ST_RUN) && (din != din_q_r);
  assign pop_s  = m.m_ready && !empty_s;
  assign ovf    = ovf_r;

  // Saturating next value of the hold counter.
  always_comb begin
    inc32_s   = sat_inc(32'(cnt_r), CNT_MAX32);
    cnt_inc_s = inc32_s[CNT_W-1:0];
  end

  // Arm on the first edge out of reset, then track runs and drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      din_q_r <= 8'h00;
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          din_q_r <= din;
          cnt_r   <= CNT_ONE;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (din != din_q_r) begin
            din_q_r <= din;
            cnt_r   <= CNT_ONE;
            // A pop on the same edge frees the slot, so only a stalled full FIFO drops.
            if (full_s && !pop_s) begin
              ovf_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  lab2_sync_fifo #(
    .W     (8 + CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (m.m_ready),
    .din   ({din_q_r, cnt_r}),
    .dout  (m.m_data),
    .valid (m.m_valid),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

endmodule

// File: tb/tb_lab2_hold_meter.sv
// Bench for lab2_hold_meter: a 16-bit and a 4-bit counter instance share the
// same stimulus and are checked against a run-length queue model.
module tb_lab2_hold_meter;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [7:0]    din;
  logic          ready;
  logic [LW-1:0] level_a;
  logic [LW-1:0] level_b;
  logic          ovf_a;
  logic          ovf_b;

  lab2_hold_meter_if #(.CNT_W(16)) bus_a ();
  lab2_hold_meter_if #(.CNT_W(4))  bus_b ();

  assign bus_a.m_ready = ready;
  assign bus_b.m_ready = ready;

  lab2_hold_meter #(.CNT_W(16), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .din(din), .m(bus_a), .level(level_a), .ovf(ovf_a)
  );
  lab2_hold_meter #(.CNT_W(4), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .din(din), .m(bus_b), .level(level_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always begin
    #63 clk = 1'b1;
    #62 clk = 1'b0;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: raw run lengths, saturation applied only when comparing.
  typedef struct {
    logic [7:0]  v;
    int unsigned n;
  } mrec_t;
  mrec_t       mq[$];
  bit          m_armed;
  bit          m_ovf;
  logic [7:0]  m_cur;
  int unsigned m_run;

  typedef struct {
    logic [7:0]  din;
    logic        rdy;
    logic [3:0]  lvl;
    logic        vld;
    logic [23:0] da;
    logic [11:0] db;
  } vec_t;
  vec_t vt[9];

  function automatic int unsigned cap(input int unsigned n, input int unsigned mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_armed = 1'b0;
    m_ovf   = 1'b0;
    m_cur   = 8'h00;
    m_run   = 0;
  endtask

  task automatic model_edge();
    mrec_t r;
    if (ready && (mq.size() != 0)) mq.delete(0);
    if (!m_armed) begin
      m_armed = 1'b1;
      m_cur   = din;
      m_run   = 1;
    end else if (din == m_cur) begin
      m_run++;
    end else begin
      r.v = m_cur;
      r.n = m_run;
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1'b1;
      m_cur = din;
      m_run = 1;
    end
  endtask

  task automatic check_model();
    logic [23:0] ea;
    logic [11:0] eb;
    chk("level_a", 32'(level_a), 32'(mq.size()));
    chk("level_b", 32'(level_b), 32'(mq.size()));
    chk("valid_a", 32'(bus_a.m_valid), 32'(mq.size() != 0));
    chk("valid_b", 32'(bus_b.m_valid), 32'(mq.size() != 0));
    chk("ovf_a", 32'(ovf_a), 32'(m_ovf));
    chk("ovf_b", 32'(ovf_b), 32'(m_ovf));
    if (mq.size() != 0) begin
      ea = {mq[0].v, 16'(cap(mq[0].n, 32'd65535))};
      eb = {mq[0].v, 4'(cap(mq[0].n, 32'd15))};
      chk("data_a", 32'(bus_a.m_data), 32'(ea));
      chk("data_b", 32'(bus_b.m_data), 32'(eb));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_model();
  endtask

  initial begin
    vt[0] = '{din: 8'h05, rdy: 1'b0, lvl: 4'd0, vld: 1'b0, da: 24'h000000, db: 12'h000};
    vt[1] = '{din: 8'h05, rdy: 1'b0, lvl: 4'd0, vld: 1'b0, da: 24'h000000, db: 12'h000};
    vt[2] = '{din: 8'h05, rdy: 1'b0, lvl: 4'd0, vld: 1'b0, da: 24'h000000, db: 12'h000};
    vt[3] = '{din: 8'h05, rdy: 1'b0, lvl: 4'd0, vld: 1'b0, da: 24'h000000, db: 12'h000};
    vt[4] = '{din: 8'h06, rdy: 1'b0, lvl: 4'd1, vld: 1'b1, da: 24'h050004, db: 12'h054};
    vt[5] = '{din: 8'h06, rdy: 1'b0, lvl: 4'd1, vld: 1'b1, da: 24'h050004, db: 12'h054};
    vt[6] = '{din: 8'h06, rdy: 1'b0, lvl: 4'd1, vld: 1'b1, da: 24'h050004, db: 12'h054};
    vt[7] = '{din: 8'h07, rdy: 1'b1, lvl: 4'd1, vld: 1'b1, da: 24'h060003, db: 12'h063};
    vt[8] = '{din: 8'h07, rdy: 1'b1, lvl: 4'd0, vld: 1'b0, da: 24'h000000, db: 12'h000};

    model_reset();
    rst   = 1'b1;
    din   = 8'h00;
    ready = 1'b0;
    #1 rst = 1'b0;
    #49;
    // Reset state, before any clock edge.
    chk("rst_valid_a", 32'(bus_a.m_valid), 32'd0);
    chk("rst_level_a", 32'(level_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_data_a", 32'(bus_a.m_data), 32'd0);
    chk("rst_valid_b", 32'(bus_b.m_valid), 32'd0);
    chk("rst_level_b", 32'(level_b), 32'd0);
    chk("rst_ovf_b", 32'(ovf_b), 32'd0);
    chk("rst_data_b", 32'(bus_b.m_data), 32'd0);
    #50 rst = 1'b1;

    // Basic run-length records from the vector table.
    for (int i = 0; i < 9; i++) begin
      din   = vt[i].din;
      ready = vt[i].rdy;
      tick();
      chk("tbl_level", 32'(level_a), 32'(vt[i].lvl));
      chk("tbl_valid", 32'(bus_a.m_valid), 32'(vt[i].vld));
      if (vt[i].vld) begin
        chk("tbl_data_a", 32'(bus_a.m_data), 32'(vt[i].da));
        chk("tbl_data_b", 32'(bus_b.m_data), 32'(vt[i].db));
      end
    end

    // Full FIFO with a pop on the push edge.
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      din = 8'(8'h10 + i);
      tick();
    end
    chk("fill_level", 32'(level_a), 32'(DEPTH));
    din   = 8'h18;
    ready = 1'b1;
    tick();
    chk("fullpop_level", 32'(level_a), 32'(DEPTH));
    chk("fullpop_ovf_a", 32'(ovf_a), 32'd0);
    chk("fullpop_ovf_b", 32'(ovf_b), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("fullpop_last", 32'(bus_a.m_data), 32'h170001);
    chk("fullpop_lvl1", 32'(level_a), 32'd1);
    tick();
    chk("fullpop_empty", 32'(level_a), 32'd0);

    // Overflow: two records beyond capacity are dropped.
    ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      din = 8'(8'h20 + i);
      tick();
    end
    chk("ovf_level", 32'(level_a), 32'(DEPTH));
    chk("ovf_flag_a", 32'(ovf_a), 32'd1);
    chk("ovf_flag_b", 32'(ovf_b), 32'd1);
    ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      chk("ovf_drain_val", 32'(bus_a.m_data[23:16]), (j == 0) ? 32'h18 : 32'(32'h20 + j - 1));
      tick();
    end
    chk("ovf_drained", 32'(level_a), 32'd0);

    // Reset pulse between edges with three records queued.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'h30 + i);
      tick();
    end
    chk("mid_level3", 32'(level_a), 32'd3);
    #20 rst = 1'b0;
    #5;
    chk("mid_level_a", 32'(level_a), 32'd0);
    chk("mid_valid_a", 32'(bus_a.m_valid), 32'd0);
    chk("mid_ovf_a", 32'(ovf_a), 32'd0);
    chk("mid_level_b", 32'(level_b), 32'd0);
    chk("mid_valid_b", 32'(bus_b.m_valid), 32'd0);
    chk("mid_data_a", 32'(bus_a.m_data), 32'd0);
    model_reset();
    #10 rst = 1'b1;
    din = 8'h40;
    tick();
    chk("arm_only", 32'(level_a), 32'd0);
    din = 8'h41;
    tick();
    chk("arm_first_rec", 32'(bus_a.m_data), 32'h400001);

    // Randomised stretch alternating mostly-stalled and mostly-draining phases.
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 50; k++) begin
        if ($urandom_range(0, 2) == 0) din = 8'($urandom_range(0, 3));
        ready = ($urandom_range(0, 99) < ((b % 2 == 0) ? 20 : 85));
        tick();
      end
    end

    // Saturation of the 4-bit counter on a 20-edge hold.
    ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    ready = 1'b0;
    din   = 8'hAA;
    for (int i = 0; i < 20; i++) tick();
    din = 8'h55;
    tick();
    chk("sat_level", 32'(level_a), 32'd2);
    ready = 1'b1;
    tick();
    chk("sat_data_a", 32'(bus_a.m_data), 32'hAA0014);
    chk("sat_data_b", 32'(bus_b.m_data), 32'hAAF);
    tick();
    chk("sat_drained", 32'(level_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
